wordcopy_csr: RTL and testbench
===============================

Name: wordcopy_csr

Overview:
- CPU-facing Avalon-MM slave register block that sits directly upstream of the SDRAM word-copy master.
- Latches destination, source and word count from the CPU, launches the copy engine, and tracks its busy/done status.
- Stalls the CPU while a copy is in flight and keeps a completion counter and an error flag.

Parameters:
START_TIMEOUT, 16, cycles LAUNCH waits for engine copying=1 before flagging error (min 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
slave_address  in  3  word offset into register map
slave_read  in  1  Avalon read strobe
slave_readdata  out  32  read data, zero read latency (valid same cycle waitrequest low)
slave_write  in  1  Avalon write strobe
slave_writedata  in  32  write data
slave_waitrequest  out  1  stall CPU access
dest_addr  out  32  byte address to engine
src_addr  out  32  byte address to engine
num_words  out  32  word count to engine
enable  out  1  launch request to engine
copying  in  1  engine busy indication

Behaviour:
- Clock and reset: one clock clk. Reset rst_n is asynchronous, active-low.
- Register map (word offsets):
  - 0 CTRL/STATUS. Write: bit0=start, bit1=clear_done. Read: {29'b0, error, done, busy}.
  - 1 DEST, 2 SRC, 3 NUM (R/W).
  - 4 COUNT (RO, completed copies).
  - 5-7: read 0, writes ignored.
- DEST/SRC writes force bits[1:0]=0 (word aligned). NUM stored full 32 bits.
- Reset values: all registers 0, state IDLE, enable=0, waitrequest=0, readdata=0, outputs dest/src/num=0.
- Async reset mid-copy: immediate return to IDLE and all registers cleared. The engine shares rst_n.
- FSM states: IDLE, LAUNCH, RUN, FINISH. busy = (state != IDLE).
  - IDLE: a write to offset 0 with bit0=1 is accepted.
    - NUM!=0: go to LAUNCH, clear done and error, load timer=0.
    - NUM==0: go straight to FINISH; enable never asserted (the engine would otherwise copy 1 word).
  - LAUNCH: enable=1.
    - copying==1: go to RUN.
    - timer reaches START_TIMEOUT-1 without copying: set error, go to FINISH.
    - timer increments each cycle.
  - RUN: enable=0. copying==0: go to FINISH.
  - FINISH: single cycle; done<=1, COUNT<=COUNT+1 (wraps at 2^32), then IDLE.
- Start write with bit0=1 and bit1=1: start wins; done is cleared anyway.
- Write with bit0=0, bit1=1: clears done only. Legal in any state; never stalls.
- waitrequest:
  - Asserted combinationally when busy and a write targets offsets 0-3 with bit0=1 (for offset 0) or any write to offsets 1-3.
  - The write completes in the first cycle busy is low; a start accepted there launches a new copy.
  - Reads never stall.
- Simultaneous FINISH and a CTRL clear_done write: the set wins (done=1).
- dest/src/num outputs are driven directly from registers; they are stable throughout LAUNCH/RUN because writes stall.

Optional Feature:
- WORDCOPY_IRQ_EN defined:
  - Adds output irq (1 bit) = done & ie, where ie is CTRL write bit2.
  - ie is readable at status bit3; reset value 0.
  - irq drops the cycle after clear_done or a new start.
- Undefined: no irq port; bit2 is ignored on write and status bit3 reads 0.

Test Plan:
- Write DEST=0x1003, SRC=0x2000, NUM=4, CTRL=1; engine model raises copying 1 cycle after enable for 20 cycles -> dest_addr=0x1000, enable high exactly until copying seen. Status reads busy=1, then 0x2 (done). COUNT=1.
- NUM=0, CTRL=1 -> enable never asserts, busy for exactly 1 cycle (FINISH), done=1, COUNT increments.
- During RUN, CPU writes SRC=0x3000 -> waitrequest held until the cycle after copying falls. SRC updates only then; src_addr is unchanged during the copy.
- Engine model never raises copying, START_TIMEOUT=16 -> enable high 16 cycles, status=0x6 (error, done), COUNT=1.
- Assert rst_n low mid-RUN -> enable=0, all registers read 0, waitrequest=0 immediately (asynchronous).
- WORDCOPY_IRQ_EN: CTRL=0x5 (start+ie), copy completes -> irq=1; CTRL=0x2 -> irq=0 next cycle, ie still set.

Source files
------------

// File: rtl/wordcopy_csr.sv
// wordcopy_csr: CPU-facing Avalon-MM register block that launches the SDRAM
// word-copy engine and tracks its busy/done/error status and a completion count.
// Ports: clk, rst_n (async, active-low); Avalon slave_address/read/readdata/
// write/writedata/waitrequest; engine side dest_addr, src_addr, num_words,
// enable (out) and copying (in). Optional irq output when WORDCOPY_IRQ_EN
// is defined (CTRL bit2 = interrupt enable, readable at status bit3).
module wordcopy_csr #(
    parameter int START_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic        slave_waitrequest,
    output logic [31:0] dest_addr,
    output logic [31:0] src_addr,
    output logic [31:0] num_words,
    output logic        enable,
    input  logic        copying
`ifdef WORDCOPY_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

    localparam int TW = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(START_TIMEOUT - 1);

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic [31:0]   count;
    logic          done;
    logic          error;
    logic          ie;
    logic          busy;
    logic          wr_ok;
    logic          ctrl_wr;
    logic          start;
    logic          clr;
    logic          set_err;

    assign busy = (state != IDLE);

    // A start or a parameter write would disturb an in-flight copy, so it
    // is held off until the FSM is back in IDLE. Pure clear_done never stalls.
    assign slave_waitrequest = busy && slave_write &&
        ((slave_address == 3'd0 && slave_writedata[0]) ||
         slave_address == 3'd1 || slave_address == 3'd2 ||
         slave_address == 3'd3);

    assign wr_ok   = slave_write && !slave_waitrequest;
    assign ctrl_wr = wr_ok && (slave_address == 3'd0);
    assign start   = ctrl_wr && slave_writedata[0];
    assign clr     = ctrl_wr && slave_writedata[1];
    assign set_err = (state == LAUNCH) && !copying && (timer == T_LAST);

    always_comb begin
        state_nx = state;
        enable   = 1'b0;
        unique case (state)
            IDLE: begin
                // A zero count skips the engine: it would copy one word.
                if (start)
                    state_nx = (num_words == 32'd0) ? FINISH : LAUNCH;
            end
            LAUNCH: begin
                enable = 1'b1;
                if (copying)
                    state_nx = RUN;
                else if (timer == T_LAST)
                    state_nx = FINISH;
            end
            RUN: begin
                if (!copying)
                    state_nx = FINISH;
            end
            FINISH: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            dest_addr <= '0;
            src_addr  <= '0;
            num_words <= '0;
            count     <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == LAUNCH)
                timer <= timer + 1'b1;
            else
                timer <= '0;
            if (wr_ok) begin
                case (slave_address)
                    3'd1: dest_addr <= {slave_writedata[31:2], 2'b00};
                    3'd2: src_addr  <= {slave_writedata[31:2], 2'b00};
                    3'd3: num_words <= slave_writedata;
                    default: ;
                endcase
            end
            // Completion beats a same-cycle clear_done.
            if (state == FINISH)
                done <= 1'b1;
            else if (start || clr)
                done <= 1'b0;
            if (set_err)
                error <= 1'b1;
            else if (start)
                error <= 1'b0;
            if (state == FINISH)
                count <= count + 32'd1;
        end
    end

`ifdef WORDCOPY_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ie <= 1'b0;
        else if (start)
            ie <= slave_writedata[2];
    end
    assign irq = done & ie;
`else
    assign ie = 1'b0;
`endif

    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                3'd0: slave_readdata = {28'd0, ie, error, done, busy};
                3'd1: slave_readdata = dest_addr;
                3'd2: slave_readdata = src_addr;
                3'd3: slave_readdata = num_words;
                3'd4: slave_readdata = count;
                default: slave_readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_wordcopy_csr.sv
// tb_wordcopy_csr: directed self-checking bench for wordcopy_csr with a
// behavioural copy engine and a queue of expected register reads.
module tb_wordcopy_csr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        slave_waitrequest;
    logic [31:0] dest_addr;
    logic [31:0] src_addr;
    logic [31:0] num_words;
    logic        enable;
    logic        copying;
`ifdef WORDCOPY_IRQ_EN
    logic        irq;
`endif

    int          passed = 0;
    int          total = 0;
    logic [31:0] exp_q[$];
    int          en_cnt = 0;
    int          eng_len;
    bit          eng_stuck;
    int          eng_left;

    always #5 clk = ~clk;

    wordcopy_csr #(.START_TIMEOUT(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .slave_address     (slave_address),
        .slave_read        (slave_read),
        .slave_readdata    (slave_readdata),
        .slave_write       (slave_write),
        .slave_writedata   (slave_writedata),
        .slave_waitrequest (slave_waitrequest),
        .dest_addr         (dest_addr),
        .src_addr          (src_addr),
        .num_words         (num_words),
        .enable            (enable),
        .copying           (copying)
`ifdef WORDCOPY_IRQ_EN
        ,
        .irq               (irq)
`endif
    );

    // Engine: raises copying the cycle after it sees enable, holds eng_len.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copying  <= 1'b0;
            eng_left <= 0;
        end else if (copying) begin
            if (eng_left == 1)
                copying <= 1'b0;
            eng_left <= eng_left - 1;
        end else if (enable && !eng_stuck) begin
            copying  <= 1'b1;
            eng_left <= eng_len;
        end
    end

    always @(posedge clk)
        if (enable)
            en_cnt <= en_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        slave_read    = 1'b1;
        slave_address = a;
        #1;
        d = slave_readdata;
        slave_read = 1'b0;
    endtask

    task automatic expect_rd(input string tag, input logic [2:0] a,
                             input logic [31:0] e);
        logic [31:0] d;
        exp_q.push_back(e);
        rd(a, d);
        chk(tag, d, exp_q.pop_front());
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d,
                      output int stalls);
        @(posedge clk);
        #1;
        slave_write     = 1'b1;
        slave_address   = a;
        slave_writedata = d;
        stalls = 0;
        @(negedge clk);
        while (slave_waitrequest && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 200)
            chk("wr_stall_bound", {31'd0, slave_waitrequest}, 32'd0);
        @(posedge clk);
        #1;
        slave_write = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] d;
        int n;
        n = 0;
        rd(3'd0, d);
        while (d[0] && n < 200) begin
            @(posedge clk);
            #1;
            rd(3'd0, d);
            n++;
        end
        chk({tag, "_idle"}, {31'd0, d[0]}, 32'd0);
    endtask

    initial begin
        int s;
        int e0;
        int stalls;
        int lowcnt;
        bit held;
        logic [31:0] cnt;

        rst_n = 1'b0;
        slave_address = '0;
        slave_read = 1'b0;
        slave_write = 1'b0;
        slave_writedata = '0;
        eng_len = 20;
        eng_stuck = 1'b0;
        cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_enable", {31'd0, enable}, 0);
        chk("rst_wait", {31'd0, slave_waitrequest}, 0);
        chk("rst_dest", dest_addr, 0);
        expect_rd("rst_status", 3'd0, 32'h0);
        expect_rd("rst_count", 3'd4, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal copy
        wr(3'd1, 32'h1003, s);
        wr(3'd2, 32'h2000, s);
        wr(3'd3, 32'd4, s);
        chk("dest_align", dest_addr, 32'h1000);
        expect_rd("rd_dest", 3'd1, 32'h1000);
        e0 = en_cnt;
        wr(3'd0, 32'h1, s);
        chk("launch_en", {31'd0, enable}, 1);
        expect_rd("launch_busy", 3'd0, 32'h1);
        wait_idle("copy1");
        expect_rd("copy1_done", 3'd0, 32'h2);
        chk("copy1_en_cycles", 32'(en_cnt - e0), 32'd2);
        cnt++;
        expect_rd("copy1_count", 3'd4, cnt);
        expect_rd("copy1_num", 3'd3, 32'd4);

        // Zero word count
        wr(3'd3, 32'd0, s);
        e0 = en_cnt;
        wr(3'd0, 32'h1, s);
        expect_rd("nz_finish_busy", 3'd0, 32'h1);
        chk("nz_enable", {31'd0, enable}, 0);
        @(posedge clk);
        #1;
        expect_rd("nz_done", 3'd0, 32'h2);
        chk("nz_en_cycles", 32'(en_cnt - e0), 32'd0);
        cnt++;
        expect_rd("nz_count", 3'd4, cnt);

        // SRC write during RUN stalls until FSM idles
        wr(3'd3, 32'd3, s);
        wr(3'd0, 32'h1, s);
        repeat (4) @(posedge clk);
        wr(3'd0, 32'h2, stalls);
        chk("clr_nostall", 32'(stalls), 0);
        @(posedge clk);
        #1;
        slave_write     = 1'b1;
        slave_address   = 3'd2;
        slave_writedata = 32'h3000;
        stalls = 0;
        lowcnt = 0;
        held = 1'b1;
        @(negedge clk);
        while (slave_waitrequest && stalls < 200) begin
            if (src_addr !== 32'h2000) held = 1'b0;
            if (!copying) lowcnt++;
            stalls++;
            @(negedge clk);
        end
        chk("src_stalled", 32'(stalls > 5), 1);
        chk("src_held", {31'd0, held}, 1);
        chk("src_release", 32'(lowcnt), 2);
        @(posedge clk);
        #1;
        slave_write = 1'b0;
        chk("src_new", src_addr, 32'h3000);
        expect_rd("src_rd", 3'd2, 32'h3000);
        expect_rd("run_done", 3'd0, 32'h2);
        cnt++;
        expect_rd("run_count", 3'd4, cnt);

        // Engine never responds
        eng_stuck = 1'b1;
        e0 = en_cnt;
        wr(3'd0, 32'h1, s);
        wait_idle("tmo");
        chk("tmo_en_cycles", 32'(en_cnt - e0), 32'd16);
        expect_rd("tmo_status", 3'd0, 32'h6);
        cnt++;
        expect_rd("tmo_count", 3'd4, cnt);
        wr(3'd0, 32'h2, s);
        expect_rd("clr_keep_err", 3'd0, 32'h4);
        eng_stuck = 1'b0;
        wr(3'd0, 32'h3, s);
        wait_idle("recover");
        expect_rd("recover_status", 3'd0, 32'h2);
        cnt++;
        expect_rd("recover_count", 3'd4, cnt);

        // Unmapped offsets
        wr(3'd5, 32'hFFFF_FFFF, s);
        expect_rd("off5", 3'd5, 32'h0);
        expect_rd("off7", 3'd7, 32'h0);

        // Async reset mid-RUN
        wr(3'd0, 32'h1, s);
        repeat (4) @(posedge clk);
        #1;
        slave_write     = 1'b1;
        slave_address   = 3'd1;
        slave_writedata = 32'h55;
        #1;
        chk("pre_rst_wait", {31'd0, slave_waitrequest}, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_enable", {31'd0, enable}, 0);
        chk("arst_wait", {31'd0, slave_waitrequest}, 0);
        slave_write = 1'b0;
        expect_rd("arst_dest", 3'd1, 32'h0);
        expect_rd("arst_src", 3'd2, 32'h0);
        expect_rd("arst_num", 3'd3, 32'h0);
        expect_rd("arst_count", 3'd4, 32'h0);
        expect_rd("arst_status", 3'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef WORDCOPY_IRQ_EN
        wr(3'd3, 32'd2, s);
        wr(3'd0, 32'h5, s);
        wait_idle("irq");
        chk("irq_set", {31'd0, irq}, 1);
        expect_rd("irq_status", 3'd0, 32'hA);
        wr(3'd0, 32'h2, s);
        chk("irq_clr", {31'd0, irq}, 0);
        expect_rd("irq_ie_kept", 3'd0, 32'h8);
`else
        wr(3'd3, 32'd2, s);
        wr(3'd0, 32'h5, s);
        wait_idle("noirq");
        expect_rd("noirq_status", 3'd0, 32'h2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
